sccb_responder: RTL
===================

// Module: sccb_responder
// PURPOSE
//  Synthesizable SCCB/I2C target (responder) with a 256x8 register file: the far end of the
//  camera-config initiator driving the JD open-drain SCL/SDA pair. Used in nexys-level
//  benches as a stand-in camera, and on-board as a loopback target for bring-up.
//  Accepts register writes, pointer-set and sequential reads, and drives ACK/read data.
// PARAMETERS
//  DEV_ADDR     7'h21  7-bit target address (write byte 0x42, read byte 0x43)
//  SYNC_STAGES  2      synchronizer depth on scl_in/sda_in (>=2)
// PORTS
//  clk       in   1  system clock; must be >= 8x SCL rate
//  reset     in   1  synchronous, active-high
//  scl_in    in   1  SCL pin level (async)
//  sda_in    in   1  SDA pin level (async)
//  sda_oe    out  1  1 = pull SDA low; 0 = release (top ties pad to 1'bz when 0)
//  wr_stb    out  1  one-cycle pulse when a data byte is written into the register file
//  wr_addr   out  8  register index of the last write (valid with wr_stb, held after)
//  wr_data   out  8  byte of the last write (valid with wr_stb, held after)
//  busy      out  1  1 between an address-matched START and the following STOP
//  peek_addr in   8  bench/debug read index
//  peek_data out  8  regfile[peek_addr], combinational
// BEHAVIOUR
//  - Reset: sda_oe=0, wr_stb=0, wr_addr=0, wr_data=0, busy=0, pointer=0, all regs=0, state IDLE.
//    Reset mid-transfer aborts immediately; SDA released in the same cycle reset is sampled.
//  - Inputs pass SYNC_STAGES flops, then one history flop; edges are seen SYNC_STAGES+1 clks
//    after the pin. START = SDA fall while SCL high; STOP = SDA rise while SCL high.
//  - Data bits are sampled on SCL rise, MSB first; sda_oe changes only on SCL fall (never while
//    SCL high), except the asynchronous-to-protocol release on STOP/reset.
//  - States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
//    IDLE -START-> ADDR. After 8 bits: addr[7:1]==DEV_ADDR -> ADDR_ACK (busy=1), else IGNORE.
//    ADDR_ACK: drive sda_oe=1 from SCL fall after bit 8 to next SCL fall; then R/W=0 -> PTR,
//      R/W=1 -> RDATA (first bit driven on that same fall).
//    PTR: 8 bits -> pointer; PTR_ACK ACKs -> WDATA.
//    WDATA: 8 bits -> regfile[pointer]; wr_stb pulses one clk at bit-8 SCL rise;
//      pointer += 1 (8-bit wrap 0xFF->0x00); WDATA_ACK ACKs -> WDATA.
//    RDATA: shift regfile[pointer] out, sda_oe = ~bit; after bit 8 release SDA -> RDATA_ACK.
//    RDATA_ACK: sample initiator bit on SCL rise; 0 (ACK) -> pointer+=1, RDATA; 1 (NACK) ->
//      pointer+=1, IGNORE.
//  - START in any state (repeated start) -> ADDR, bit count 0, pointer kept. STOP in any
//    state -> IDLE, sda_oe=0, busy=0. Simultaneous STOP and reset: reset wins.
//  - IGNORE: never drives SDA; waits for START or STOP. Address mismatch never touches regs.
//  - A STOP inside a partial data byte discards it (no write, no wr_stb).
//  - peek port has no effect on protocol; reading while a write lands returns old value.
// STRUCTURE
//  - Shared package sccb_pkg: state enum/localparams, SCCB_WR_BIT/RD_BIT, default DEV_ADDR.
//  - One sub-module: sccb_line_sync (synchronizer + history, emits scl_rise, scl_fall,
//    start_det, stop_det). FSM, bit counter, shift reg and regfile live in the top.
// TESTING (bench models initiator with open-drain SDA = ~(m_oe|sda_oe))
//  1 START,0x42,0x12,0x80,STOP -> ACK on all 3 bytes; wr_stb once, wr_addr=0x12,
//    wr_data=0x80; peek(0x12)=0x80; busy 1->0 at STOP.
//  2 START,0x42,0xFF,0xAA,0xBB,STOP -> regs[0xFF]=0xAA, regs[0x00]=0xBB (pointer wrap).
//  3 START,0x42,0x12,Sr,0x43,read 2 bytes (ACK,NACK),STOP -> data 0x80 then regs[0x13]=0x00;
//    SDA released after NACK.
//  4 START,0x60,0x05,0x77,STOP -> no ACK (SDA high on 9th clk), no wr_stb, busy=0.
//  5 reset asserted mid-WDATA with sda_oe=1 -> sda_oe=0 next clk, peek(all)=0, state IDLE;
//    a following clean write succeeds.
//  6 START,0x42,0x20,4 bits,STOP -> regs[0x20] unchanged, no wr_stb, busy=0.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB/I2C register-file responder.
package sccb_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned REG_DEPTH = 256;

  localparam logic [6:0] SCCB_DEFAULT_DEV_ADDR = 7'h21;
  localparam logic       SCCB_WR_BIT           = 1'b0;
  localparam logic       SCCB_RD_BIT           = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } sccb_state_e;

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronizes SCL/SDA pins and flags SCL edges plus START/STOP conditions.
module sccb_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_lvl_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_hist_q;
  logic                   sda_hist_q;
  logic                   scl_s;
  logic                   sda_s;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign sda_lvl_o = sda_hist_q;

  // Idle bus is high on both lines, so the chain resets to 1 to avoid false edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_hist_q  <= 1'b1;
      sda_hist_q  <= 1'b1;
      scl_rise_o  <= 1'b0;
      scl_fall_o  <= 1'b0;
      start_det_o <= 1'b0;
      stop_det_o  <= 1'b0;
    end else begin
      scl_sync_q  <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q  <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_hist_q  <= scl_s;
      sda_hist_q  <= sda_s;
      scl_rise_o  <= scl_s & ~scl_hist_q;
      scl_fall_o  <= ~scl_s & scl_hist_q;
      start_det_o <= scl_s & scl_hist_q & ~sda_s & sda_hist_q;
      stop_det_o  <= scl_s & scl_hist_q & sda_s & ~sda_hist_q;
    end
  end

endmodule

// File: rtl/sccb_responder.sv
// SCCB/I2C target with a 256x8 register file: pointer-set, burst writes and sequential reads.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = SCCB_DEFAULT_DEV_ADDR,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              wr_stb,
  output logic [BYTE_W-1:0] wr_addr,
  output logic [BYTE_W-1:0] wr_data,
  output logic              busy,
  input  logic [BYTE_W-1:0] peek_addr,
  output logic [BYTE_W-1:0] peek_data
);

  sccb_state_e       state_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [BYTE_W-1:0] shift_q;
  logic [BYTE_W-1:0] ptr_q;
  logic              rw_q;
  logic [BYTE_W-1:0] regs_q [REG_DEPTH];

  logic              sda_lvl;
  logic              scl_rise;
  logic              scl_fall;
  logic              start_det;
  logic              stop_det;
  logic [BYTE_W-1:0] rx_byte;
  logic [BYTE_W-1:0] ptr_inc;
  logic              last_bit;

  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk         (clk),
    .reset       (reset),
    .scl_i       (scl_in),
    .sda_i       (sda_in),
    .sda_lvl_o   (sda_lvl),
    .scl_rise_o  (scl_rise),
    .scl_fall_o  (scl_fall),
    .start_det_o (start_det),
    .stop_det_o  (stop_det)
  );

  assign rx_byte   = {shift_q[BYTE_W-2:0], sda_lvl};
  assign ptr_inc   = ptr_q + BYTE_W'(1);
  assign last_bit  = (bit_cnt_q == CNT_W'(BYTE_W - 1));
  assign peek_data = regs_q[peek_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= SCCB_WR_BIT;
      sda_oe    <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      regs_q    <= '{default: '0};
    end else begin
      wr_stb <= 1'b0;
      if (stop_det) begin
        state_q   <= ST_IDLE;
        bit_cnt_q <= '0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else if (start_det) begin
        state_q   <= ST_ADDR;
        bit_cnt_q <= '0;
      end else begin
        case (state_q)
          // Receive byte: shift on SCL rise, act on the 8th bit.
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= last_bit ? '0 : bit_cnt_q + CNT_W'(1);
              if (last_bit) begin
                case (state_q)
                  ST_ADDR: begin
                    rw_q <= rx_byte[0];
                    if (rx_byte[7:1] == DEV_ADDR) begin
                      state_q <= ST_ADDR_ACK;
                      busy    <= 1'b1;
                    end else begin
                      state_q <= ST_IGNORE;
                    end
                  end
                  ST_PTR: begin
                    ptr_q   <= rx_byte;
                    state_q <= ST_PTR_ACK;
                  end
                  default: begin
                    regs_q[ptr_q] <= rx_byte;
                    wr_stb        <= 1'b1;
                    wr_addr       <= ptr_q;
                    wr_data       <= rx_byte;
                    ptr_q         <= ptr_inc;
                    state_q       <= ST_WDATA_ACK;
                  end
                endcase
              end
            end
          end
          // First SCL fall pulls SDA for the ACK slot, the second releases it.
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else if (state_q == ST_ADDR_ACK && rw_q == SCCB_RD_BIT) begin
                state_q <= ST_RDATA;
                shift_q <= {regs_q[ptr_q][BYTE_W-2:0], 1'b0};
                sda_oe  <= ~regs_q[ptr_q][BYTE_W-1];
              end else begin
                sda_oe  <= 1'b0;
                state_q <= (state_q == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
              end
            end
          end
          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end else if (scl_fall) begin
              if (bit_cnt_q == CNT_W'(BYTE_W)) begin
                sda_oe    <= 1'b0;
                bit_cnt_q <= '0;
                state_q   <= ST_RDATA_ACK;
              end else begin
                sda_oe  <= ~shift_q[BYTE_W-1];
                shift_q <= {shift_q[BYTE_W-2:0], 1'b0};
              end
            end
          end
          ST_RDATA_ACK: begin
            if (scl_rise) begin
              ptr_q <= ptr_inc;
              if (!sda_lvl) begin
                shift_q <= regs_q[ptr_inc];
                state_q <= ST_RDATA;
              end else begin
                state_q <= ST_IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
